fft_stream_ctrl: RTL and testbench

//  Streaming front/back end for the parallel N-point IEEE-754 single-precision fft core. Collects

---
 rtl/fft_pkg.sv | 21 ++
 rtl/fft_frame_buf.sv | 36 +++
 rtl/fft_stream_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_fft_stream_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the streaming fft front/back end.
package fft_pkg;

  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } cplx_t;

  typedef logic [1:0] state_t;

  localparam state_t LOAD   = 2'd0;
  localparam state_t START  = 2'd1;
  localparam state_t WAIT   = 2'd2;
  localparam state_t UNLOAD = 2'd3;

  localparam logic FFT_MODE  = 1'b1;
  localparam logic IFFT_MODE = 1'b0;

endpackage

// File: rtl/fft_frame_buf.sv
// NPTS-entry complex register file: serial write, parallel load, parallel read.
module fft_frame_buf
  import fft_pkg::*;
#(
  parameter int unsigned NPTS  = 8,
  parameter int unsigned LOG2N = 3
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [LOG2N-1:0] wr_idx,
  input  cplx_t            wr_data,
  input  logic             ld_en,
  input  cplx_t            ld_data [NPTS],
  output cplx_t            q       [NPTS]
);

  cplx_t mem_q [NPTS];
  cplx_t mem_d [NPTS];

  // Parallel load takes priority over a serial write.
  always_comb begin
    mem_d = mem_q;
    if (ld_en) begin
      mem_d = ld_data;
    end else if (wr_en) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign q = mem_q;

endmodule

// File: rtl/fft_stream_ctrl.sv
// Streams NPTS samples into a parallel fft core and streams the result back out in bin order.
module fft_stream_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned NPTS    = 8,
  parameter int unsigned LOG2N   = 3,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DW-1:0]        s_real,
  input  logic [DW-1:0]        s_imag,
  input  logic                 s_last,
  input  logic                 s_switch,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DW-1:0]        m_real,
  output logic [DW-1:0]        m_imag,
  output logic [LOG2N-1:0]     m_index,
  output logic                 m_last,
  output logic                 m_error,
  output logic                 core_str_sig,
  output logic                 core_switch,
  output logic [NPTS*DW-1:0]   core_x_real,
  output logic [NPTS*DW-1:0]   core_x_imag,
  input  logic [NPTS*DW-1:0]   core_y_real,
  input  logic [NPTS*DW-1:0]   core_y_imag,
  input  logic                 core_done_sig,
  input  logic                 core_error,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(NPTS - 1);

  state_t           state_q, state_d;
  logic [LOG2N-1:0] wr_idx_q, wr_idx_d;
  logic [LOG2N-1:0] rd_idx_q, rd_idx_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             err_q, err_d;
  logic             err_len_q, err_len_d;
  logic             core_switch_q, core_switch_d;
  logic             frame_err_q, frame_err_d;
  logic             s_ready_q, s_ready_d;
  logic             busy_q, busy_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic             m_error_q, m_error_d;
  logic             str_q, str_d;

  logic  in_we, res_ld;
  cplx_t s_word;
  cplx_t in_buf      [NPTS];
  cplx_t res_buf     [NPTS];
  cplx_t y_arr       [NPTS];
  cplx_t zero_arr    [NPTS];
  cplx_t res_ld_data [NPTS];

  assign s_word = '{re: s_real, im: s_imag};

  fft_frame_buf #(.NPTS(NPTS), .LOG2N(LOG2N)) u_in_buf (
    .clk     (clk),
    .wr_en   (in_we),
    .wr_idx  (wr_idx_q),
    .wr_data (s_word),
    .ld_en   (1'b0),
    .ld_data (zero_arr),
    .q       (in_buf)
  );

  fft_frame_buf #(.NPTS(NPTS), .LOG2N(LOG2N)) u_res_buf (
    .clk     (clk),
    .wr_en   (1'b0),
    .wr_idx  ('0),
    .wr_data ('0),
    .ld_en   (res_ld),
    .ld_data (res_ld_data),
    .q       (res_buf)
  );

  // Flatten the input buffer to the core and unpack the core result; x0/y0 sit in the LSBs.
  always_comb begin
    for (int i = 0; i < NPTS; i++) begin
      core_x_real[i*DW +: DW] = in_buf[i].re;
      core_x_imag[i*DW +: DW] = in_buf[i].im;
      y_arr[i]    = '{re: core_y_real[i*DW +: DW], im: core_y_imag[i*DW +: DW]};
      zero_arr[i] = '0;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    timer_d       = timer_q;
    err_d         = err_q;
    err_len_d     = err_len_q;
    core_switch_d = core_switch_q;
    frame_err_d   = 1'b0;
    in_we         = 1'b0;
    res_ld        = 1'b0;
    res_ld_data   = y_arr;

    case (state_q)
      LOAD: begin
        if (s_valid && s_ready_q) begin
          in_we = 1'b1;
          if (wr_idx_q == '0) begin
            core_switch_d = s_switch ? FFT_MODE : IFFT_MODE;
          end
          if (wr_idx_q == LAST_IDX) begin
            state_d   = START;
            err_len_d = !s_last;
            wr_idx_d  = '0;
          end else if (s_last) begin
            frame_err_d = 1'b1;
            wr_idx_d    = '0;
          end else begin
            wr_idx_d = wr_idx_q + LOG2N'(1);
          end
        end
      end
      START: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        // A done on the final timer cycle still beats the timeout.
        if (core_done_sig) begin
          res_ld   = 1'b1;
          err_d    = err_len_q | core_error;
          rd_idx_d = '0;
          state_d  = UNLOAD;
        end else if (timer_d == TW'(TIMEOUT - 1)) begin
          res_ld      = 1'b1;
          res_ld_data = zero_arr;
          err_d       = 1'b1;
          frame_err_d = 1'b1;
          rd_idx_d    = '0;
          state_d     = UNLOAD;
        end
      end
      UNLOAD: begin
        if (m_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d = '0;
            state_d  = LOAD;
          end else begin
            rd_idx_d = rd_idx_q + LOG2N'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase

    s_ready_d = (state_d == LOAD);
    busy_d    = (state_d != LOAD);
    str_d     = (state_d == START);
    m_valid_d = (state_d == UNLOAD);
    m_last_d  = (state_d == UNLOAD) && (rd_idx_d == LAST_IDX);
    m_error_d = (state_d == UNLOAD) && err_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= LOAD;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      timer_q       <= '0;
      err_q         <= 1'b0;
      err_len_q     <= 1'b0;
      core_switch_q <= FFT_MODE;
      frame_err_q   <= 1'b0;
      s_ready_q     <= 1'b1;
      busy_q        <= 1'b0;
      str_q         <= 1'b0;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      m_error_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      timer_q       <= timer_d;
      err_q         <= err_d;
      err_len_q     <= err_len_d;
      core_switch_q <= core_switch_d;
      frame_err_q   <= frame_err_d;
      s_ready_q     <= s_ready_d;
      busy_q        <= busy_d;
      str_q         <= str_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      m_error_q     <= m_error_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign busy         = busy_q;
  assign core_str_sig = str_q;
  assign core_switch  = core_switch_q;
  assign frame_err    = frame_err_q;
  assign m_valid      = m_valid_q;
  assign m_last       = m_last_q;
  assign m_error      = m_error_q;
  assign m_index      = rd_idx_q;
  assign m_real       = res_buf[rd_idx_q].re;
  assign m_imag       = res_buf[rd_idx_q].im;

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Randomized bench for fft_stream_ctrl with a frame-level reference model and a core stand-in.
module tb_fft_stream_ctrl;

  localparam int NPTS    = 8;
  localparam int TIMEOUT = 4096;

  logic clk, rst_n;
  logic s_valid, s_ready, s_last, s_switch;
  logic [31:0] s_real, s_imag;
  logic m_valid, m_ready, m_last, m_error;
  logic [31:0] m_real, m_imag;
  logic [2:0] m_index;
  logic core_str_sig, core_switch, core_done_sig, core_error, frame_err, busy;
  logic [NPTS*32-1:0] core_x_real, core_x_imag, core_y_real, core_y_imag;

  fft_stream_ctrl #(.NPTS(NPTS), .LOG2N(3), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag),
    .s_last(s_last), .s_switch(s_switch),
    .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
    .m_index(m_index), .m_last(m_last), .m_error(m_error),
    .core_str_sig(core_str_sig), .core_switch(core_switch),
    .core_x_real(core_x_real), .core_x_imag(core_x_imag),
    .core_y_real(core_y_real), .core_y_imag(core_y_imag),
    .core_done_sig(core_done_sig), .core_error(core_error),
    .frame_err(frame_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame-level model state shared by driver, core stand-in and checker.
  logic [31:0] sent_re [NPTS];
  logic [31:0] sent_im [NPTS];
  logic [31:0] exp_re  [NPTS];
  logic [31:0] exp_im  [NPTS];
  logic exp_err, exp_valid, exp_mode, len_err;
  int   out_cnt = 0;
  int   frames_out = 0;
  int   str_cnt = 0;
  bit   chk_en = 0;
  bit   hold = 0, always_rdy = 0;
  bit   never_done = 0, force_y0 = 0, cerr = 0;
  int   dly = 3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Output consumer.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold) m_ready = 1'b0;
      else if (always_rdy) m_ready = 1'b1;
      else m_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Core stand-in: checks what it is started with, then answers with random data or never.
  initial begin
    int cnt;
    bit found;
    logic [31:0] yr, yi;
    core_done_sig = 1'b0;
    core_error    = 1'b0;
    core_y_real   = '0;
    core_y_imag   = '0;
    forever begin
      @(negedge clk);
      if (rst_n && core_str_sig === 1'b1) begin
        str_cnt++;
        for (int i = 0; i < NPTS; i++) begin
          chk("core_x_real", core_x_real[i*32 +: 32], sent_re[i]);
          chk("core_x_imag", core_x_imag[i*32 +: 32], sent_im[i]);
        end
        chk("core_switch_at_str", 32'(core_switch), 32'(exp_mode));
        @(negedge clk);
        chk("str_one_cycle", 32'(core_str_sig), 32'd0);
        if (never_done) begin
          for (int i = 0; i < NPTS; i++) begin
            exp_re[i] = '0;
            exp_im[i] = '0;
          end
          exp_err = 1'b1;
          exp_valid = 1'b1;
          cnt = 1;
          found = 0;
          while (!found && cnt < TIMEOUT + 8) begin
            if (frame_err) found = 1;
            else begin
              @(negedge clk);
              cnt++;
            end
          end
          chk("timeout_latency", 32'(cnt), 32'(TIMEOUT));
        end else begin
          repeat (dly - 1) @(negedge clk);
          chk("core_switch_at_done", 32'(core_switch), 32'(exp_mode));
          for (int i = 0; i < NPTS; i++) begin
            yr = $urandom;
            yi = $urandom;
            if (force_y0 && i == 0) yr = 32'h419F7EFA;
            core_y_real[i*32 +: 32] = yr;
            core_y_imag[i*32 +: 32] = yi;
            exp_re[i] = yr;
            exp_im[i] = yi;
          end
          exp_err = len_err | cerr;
          exp_valid = 1'b1;
          core_error = cerr;
          core_done_sig = 1'b1;
          // Only the first done cycle may be captured; scramble the rest.
          @(negedge clk);
          core_y_real = {8{$urandom}};
          core_y_imag = {8{$urandom}};
          core_error = !cerr;
          @(negedge clk);
          core_done_sig = 1'b0;
          core_error = 1'b0;
        end
      end
    end
  end

  // Per-cycle output checker against the frame model.
  initial begin
    bit prev_hold, prev_last_hs;
    logic [31:0] prev_re, prev_im;
    logic [2:0] prev_idx;
    prev_hold = 0;
    prev_last_hs = 0;
    prev_re = '0;
    prev_im = '0;
    prev_idx = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !chk_en) begin
        prev_hold = 0;
        prev_last_hs = 0;
      end else begin
        chk("busy_vs_s_ready", 32'(busy), 32'(!s_ready));
        if (prev_last_hs) begin
          chk("s_ready_after_last", 32'(s_ready), 32'd1);
          chk("m_valid_after_last", 32'(m_valid), 32'd0);
        end
        if (m_valid) begin
          chk("no_overlap", 32'(s_ready), 32'd0);
          if (!exp_valid) chk("unexpected_output", 32'(m_valid), 32'd0);
          else begin
            chk("m_index", 32'(m_index), 32'(out_cnt));
            chk("m_real", m_real, exp_re[out_cnt]);
            chk("m_imag", m_imag, exp_im[out_cnt]);
            chk("m_error", 32'(m_error), 32'(exp_err));
            chk("m_last", 32'(m_last), 32'(out_cnt == NPTS - 1));
          end
          if (prev_hold) begin
            chk("stall_real", m_real, prev_re);
            chk("stall_imag", m_imag, prev_im);
            chk("stall_index", 32'(m_index), 32'(prev_idx));
          end
        end else begin
          chk("m_last_idle", 32'(m_last), 32'd0);
        end
        prev_hold = m_valid && !m_ready;
        prev_last_hs = m_valid && m_ready && (m_index == 3'd7);
        prev_re = m_real;
        prev_im = m_imag;
        prev_idx = m_index;
        if (m_valid && m_ready) begin
          out_cnt++;
          if (out_cnt == NPTS) begin
            out_cnt = 0;
            exp_valid = 1'b0;
            frames_out++;
          end
        end
      end
    end
  end

  task automatic send_frame(input int n, input logic sw, input logic with_last, input bit lit);
    int t;
    t = 0;
    @(negedge clk);
    while (!s_ready && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("s_ready_wait", 32'(s_ready), 32'd1);
    exp_mode = sw;
    len_err = (n == NPTS) && !with_last;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        s_switch = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      s_real = $urandom;
      s_imag = $urandom;
      if (lit && k == 0) begin s_real = 32'h40400000; s_imag = 32'h3F800000; end
      if (lit && k == 1) begin s_real = 32'h40800000; s_imag = 32'hC0000000; end
      sent_re[k] = s_real;
      sent_im[k] = s_imag;
      s_switch = (k == 0) ? sw : 1'($urandom_range(0, 1));
      s_last = with_last && (k == n - 1);
      s_valid = 1'b1;
      @(negedge clk);
      chk("core_switch_in_frame", 32'(core_switch), 32'(sw));
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int t;
    t = 0;
    while (frames_out < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("frame_completed", 32'(frames_out >= target), 32'd1);
  endtask

  initial begin
    int exp_str, exp_frames, n, t, s;
    logic sw, wl;
    exp_str = 0;
    exp_frames = 0;
    s_valid = 0; s_last = 0; s_switch = 0; s_real = '0; s_imag = '0;
    exp_valid = 0; exp_err = 0; exp_mode = 1; len_err = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_error", 32'(m_error), 32'd0);
    chk("rst_str", 32'(core_str_sig), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_core_switch", 32'(core_switch), 32'd1);
    chk_en = 1;

    // Literal first frame, stalled consumer, known y0.
    hold = 1; force_y0 = 1; dly = 3;
    send_frame(NPTS, 1'b1, 1'b1, 1);
    exp_str++; exp_frames++;
    chk("t1_str", 32'(core_str_sig), 32'd1);
    chk("t1_x0_real", core_x_real[31:0], 32'h40400000);
    chk("t1_x1_imag", core_x_imag[63:32], 32'hC0000000);
    chk("t1_switch", 32'(core_switch), 32'd1);
    t = 0;
    while (!m_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid_held", 32'(m_valid), 32'd1);
      chk("t2_y0", m_real, 32'h419F7EFA);
      chk("t2_index0", 32'(m_index), 32'd0);
      @(negedge clk);
    end
    hold = 0; force_y0 = 0;
    wait_frames(exp_frames, 500);

    // Short frame is dropped, the next one works.
    s = str_cnt;
    send_frame(5, 1'b1, 1'b1, 0);
    chk("t3_frame_err", 32'(frame_err), 32'd1);
    chk("t3_no_str", 32'(core_str_sig), 32'd0);
    @(negedge clk);
    chk("t3_frame_err_pulse", 32'(frame_err), 32'd0);
    repeat (3) @(negedge clk);
    chk("t3_str_count", 32'(str_cnt), 32'(s));
    send_frame(NPTS, 1'($urandom_range(0, 1)), 1'b1, 0);
    exp_str++; exp_frames++;
    wait_frames(exp_frames, 500);

    // Core never answers.
    never_done = 1;
    send_frame(NPTS, 1'b1, 1'b1, 0);
    exp_str++; exp_frames++;
    wait_frames(exp_frames, TIMEOUT + 500);
    never_done = 0;

    // ifft mode, mid-frame toggles, core error.
    cerr = 1; dly = 5;
    send_frame(NPTS, 1'b0, 1'b1, 0);
    exp_str++; exp_frames++;
    wait_frames(exp_frames, 500);
    cerr = 0;

    // Randomized frames, including short and missing-last frames.
    for (int f = 0; f < 12; f++) begin
      dly = $urandom_range(1, 20);
      cerr = ($urandom_range(0, 3) == 0);
      sw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) begin
        n = $urandom_range(1, NPTS - 1);
        send_frame(n, sw, 1'b1, 0);
        chk("rand_short_err", 32'(frame_err), 32'd1);
      end else begin
        wl = ($urandom_range(0, 3) != 0);
        send_frame(NPTS, sw, wl, 0);
        exp_str++; exp_frames++;
        wait_frames(exp_frames, 500);
      end
    end
    cerr = 0;

    // Reset in the middle of unloading.
    always_rdy = 1; dly = 2;
    send_frame(NPTS, 1'b1, 1'b1, 0);
    exp_str++;
    t = 0;
    while (!(m_valid && m_index == 3'd3) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("t6_reached_idx3", 32'(m_index), 32'd3);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_cnt = 0;
    exp_valid = 1'b0;
    @(negedge clk);
    chk("t6_m_valid", 32'(m_valid), 32'd0);
    chk("t6_s_ready", 32'(s_ready), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    always_rdy = 0;
    send_frame(NPTS, 1'b0, 1'b1, 0);
    exp_str++; exp_frames++;
    wait_frames(exp_frames, 500);

    repeat (4) @(negedge clk);
    chk("str_count", 32'(str_cnt), 32'(exp_str));
    chk("frames_out", 32'(frames_out), 32'(exp_frames));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
